// File: rtl/bitwise_accum_if.sv
// Stream bundle for bitwise_accum: input beat channel plus result channel.
// Optional out_ones wire is present when BITWISE_ACCUM_POPCOUNT_EN is defined.
interface bitwise_accum_if #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 16
);
  localparam int CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int ONES_W = $clog2(WIDTH + 1);

  logic [1:0]       op;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;

  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;
  logic             out_valid;
  logic             out_ready;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
  logic [ONES_W-1:0] out_ones;
`endif

  modport master (
    output op, in_data, in_valid, in_last, out_ready,
`ifdef BITWISE_ACCUM_POPCOUNT_EN
    input  out_ones,
`endif
    input  in_ready, out_data, out_count, out_trunc, out_valid
  );

  modport slave (
    input  op, in_data, in_valid, in_last, out_ready,
`ifdef BITWISE_ACCUM_POPCOUNT_EN
    output out_ones,
`endif
    output in_ready, out_data, out_count, out_trunc, out_valid
  );
endinterface

// File: rtl/bitwise_accum.sv
// Folds a burst of WIDTH-bit words with OR/AND/XOR/NOR into one result word.
// Define BITWISE_ACCUM_POPCOUNT_EN to add the registered out_ones popcount output.
module bitwise_accum #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 16
) (
  input logic         clk,
  input logic         rst_n,
  bitwise_accum_if.slave bus
);
  localparam int CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int ONES_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // NOR accumulates as OR; the inversion is applied once when the result is formed.
  function automatic logic [WIDTH-1:0] fold_word(input logic [1:0] op_sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op_sel)
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = a | b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  function automatic logic [ONES_W-1:0] count_ones(input logic [WIDTH-1:0] w);
    logic [ONES_W-1:0] n;
    n = {ONES_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      n = n + ONES_W'(w[i]);
    end
    return n;
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_trunc_q, out_trunc_d;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
  logic [ONES_W-1:0] ones_q, ones_d;
`endif

  logic              in_ready_s;
  logic              out_valid_s;
  logic              accept_s;
  logic              first_s;
  logic [1:0]        op_eff_s;
  logic [WIDTH-1:0]  acc_fold_s;
  logic [WIDTH-1:0]  result_s;
  logic [CNT_W-1:0]  count_inc_s;
  logic              close_s;

  assign accept_s    = bus.in_valid && in_ready_s;
  assign first_s     = (state_q == ST_IDLE);
  assign op_eff_s    = first_s ? bus.op : op_q;
  assign acc_fold_s  = first_s ? bus.in_data : fold_word(op_q, acc_q, bus.in_data);
  assign result_s    = (op_eff_s == OP_NOR) ? ~acc_fold_s : acc_fold_s;
  // count_q < MAX_WORDS whenever a beat is folded, so the increment cannot wrap.
  assign count_inc_s = first_s ? CNT_W'(1) : (count_q + CNT_W'(1));
  assign close_s     = accept_s && (bus.in_last || (count_inc_s == MAX_CNT));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (close_s) begin
          state_d = ST_DONE;
        end else if (accept_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready_s  = 1'b1;
      ST_ACCUM: in_ready_s  = 1'b1;
      ST_DONE:  out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Datapath next values; result registers only load on the closing beat.
  always_comb begin
    acc_d       = acc_q;
    op_d        = op_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
    ones_d      = ones_q;
`endif
    if (accept_s) begin
      acc_d   = acc_fold_s;
      op_d    = op_eff_s;
      count_d = count_inc_s;
    end else begin
      acc_d   = acc_q;
      op_d    = op_q;
      count_d = count_q;
    end
    if (close_s) begin
      out_data_d  = result_s;
      out_count_d = count_inc_s;
      out_trunc_d = !bus.in_last;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
      ones_d      = count_ones(result_s);
`endif
    end else begin
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_trunc_d = out_trunc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= {WIDTH{1'b0}};
      op_q        <= OP_OR;
      count_q     <= {CNT_W{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
      out_trunc_q <= 1'b0;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
      ones_q      <= {ONES_W{1'b0}};
`endif
    end else begin
      acc_q       <= acc_d;
      op_q        <= op_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
      ones_q      <= ones_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_trunc = out_trunc_q;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
  assign bus.out_ones  = ones_q;
`endif

endmodule

// File: tb/tb_bitwise_accum.sv
// Scoreboard bench for bitwise_accum: a list-fold reference model queues expected
// results as beats are accepted; a monitor pops and compares whenever out_valid is high.
module tb_bitwise_accum;
  localparam int WIDTH     = 16;
  localparam int MAX_WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bitwise_accum_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus();

  bitwise_accum #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               count;
    logic             trunc;
    int               ones;
  } exp_t;

  int               checks = 0;
  int               errors = 0;
  int               ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  exp_t             exp_q[$];
  logic [WIDTH-1:0] burst_q[$];
  logic [1:0]       burst_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a burst is the list of accepted beats, reduced with the op of its first beat.
  task automatic model_accept(input logic [WIDTH-1:0] d, input logic last,
                              input logic [1:0] o, output bit closed);
    exp_t e;
    logic [WIDTH-1:0] r;
    if (burst_q.size() == 0) burst_op = o;
    burst_q.push_back(d);
    closed = last || (burst_q.size() == MAX_WORDS);
    if (closed) begin
      r = burst_q[0];
      for (int i = 1; i < burst_q.size(); i++) begin
        case (burst_op)
          2'b01:   r = r & burst_q[i];
          2'b10:   r = r ^ burst_q[i];
          default: r = r | burst_q[i];
        endcase
      end
      if (burst_op == 2'b11) r = ~r;
      e.data  = r;
      e.count = burst_q.size();
      e.trunc = !last;
      e.ones  = $countones(r);
      exp_q.push_back(e);
      burst_q.delete();
    end
  endtask

  task automatic present_and_accept(input logic [WIDTH-1:0] d, input logic last, input logic [1:0] o);
    int waited;
    bit closed;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.op       = o;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, last, o, closed);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'($urandom_range(0, 1));
    bus.in_data  = 16'($urandom);
    if (closed) begin
      @(negedge clk);
      check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    end
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input logic [1:0] o);
    @(negedge clk);
    present_and_accept(d, last, o);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_data  = 16'($urandom);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    case ($urandom_range(0, 4))
      0:       w = 16'hFFFF;
      1:       w = 16'h0000;
      default: w = 16'($urandom);
    endcase
    return w;
  endfunction

  // Monitor: drives out_ready and checks every cycle the result is presented.
  initial begin
    exp_t cur;
    bit   have_exp;
    have_exp = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        have_exp = 1'b0;
        bus.out_ready = 1'b1;
      end else begin
        case (ready_mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = ($urandom_range(0, 2) != 0);
          default: bus.out_ready = 1'b0;
        endcase
        if (bus.out_valid === 1'b1) begin
          if (!have_exp) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_result: out_valid=1 with data %0h, expected no result", bus.out_data);
            end else begin
              cur = exp_q.pop_front();
              have_exp = 1'b1;
            end
          end
          if (have_exp) begin
            check("out_data",  32'(bus.out_data),  32'(cur.data));
            check("out_count", 32'(bus.out_count), 32'(cur.count));
            check("out_trunc", 32'(bus.out_trunc), 32'(cur.trunc));
            check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
`ifdef BITWISE_ACCUM_POPCOUNT_EN
            check("out_ones", 32'(bus.out_ones), 32'(cur.ones));
`endif
          end
          if (bus.out_ready) have_exp = 1'b0;
        end
      end
    end
  end

  initial begin
    int waited;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 16'h0000;
    bus.op       = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_out_trunc", 32'(bus.out_trunc), 32'd0);
`ifdef BITWISE_ACCUM_POPCOUNT_EN
    check("rst_out_ones",  32'(bus.out_ones),  32'd0);
`endif

    // Directed patterns: OR, AND, XOR, NOR, then truncation at MAX_WORDS.
    ready_mode = 0;
    send_beat(16'h046A, 1'b0, 2'b00); send_beat(16'hDE57, 1'b1, 2'b00);
    send_beat(16'hF0F0, 1'b0, 2'b01); send_beat(16'hFF00, 1'b0, 2'b01); send_beat(16'hF3FF, 1'b1, 2'b01);
    send_beat(16'h1234, 1'b0, 2'b10); send_beat(16'h1234, 1'b0, 2'b10); send_beat(16'h00FF, 1'b1, 2'b10);
    send_beat(16'h0F00, 1'b0, 2'b11); send_beat(16'h00F0, 1'b1, 2'b11);
    send_beat(16'h0001, 1'b0, 2'b00); send_beat(16'h0002, 1'b0, 2'b00); send_beat(16'h0004, 1'b0, 2'b00);
    send_beat(16'h0008, 1'b0, 2'b00); send_beat(16'h0010, 1'b1, 2'b00);
    idle(3);

    // Backpressure: result held while a beat waits at the input.
    ready_mode = 2;
    send_beat(16'h5A5A, 1'b1, 2'b00);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.in_last  = 1'b1;
    bus.op       = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    #1 ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    present_and_accept(16'hFFFF, 1'b1, 2'b00);

    // Op change after first beat is ignored.
    send_beat(16'h0F0F, 1'b0, 2'b00); send_beat(16'hF000, 1'b1, 2'b01);
    idle(3);

    // Reset in the middle of a burst discards it.
    send_beat(16'h1111, 1'b0, 2'b10); send_beat(16'h2222, 1'b0, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    burst_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    send_beat(16'h0003, 1'b1, 2'b00);

    // Random bursts, including over-length ones that truncate, with random backpressure.
    ready_mode = 1;
    for (int b = 0; b < 300; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        idle($urandom_range(0, 2));
        send_beat(rand_word(), (k == len - 1), 2'($urandom_range(0, 3)));
      end
    end

    ready_mode = 0;
    waited = 0;
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_accum.md
Name: bitwise_accum

Overview:
- Parametrised, sequential successor to the fixed 16-bit two-operand bitwise gates.
- Folds a burst of WIDTH-bit words into one word with a selectable bitwise op: OR, AND, XOR or NOR.
- Valid/ready handshakes on input and output.
- Used as a mask-combining and reduction stage between streaming producers and ALU-side consumers.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- MAX_WORDS, 16, maximum beats per burst (>=1); CNT_W = $clog2(MAX_WORDS+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- op  input  2  op select, sampled on first beat of burst: 00 OR, 01 AND, 10 XOR, 11 NOR.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data valid.
- in_last  input  1  final beat of burst; qualified by in_valid.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  burst result.
- out_count  output  CNT_W  beats folded into out_data.
- out_trunc  output  1  burst closed by MAX_WORDS, not by in_last.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset: one clock, sync active-low; reset is decided as synchronous, active-low. On any clk edge with rst_n=0:
  - state=IDLE; acc=0; count=0; out_valid=0; out_trunc=0; op_q=00.
  - Reset mid-burst or mid-hold discards all data.
- Beat accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE. No bypass: one bubble per burst.
- IDLE, on accept:
  - acc<=in_data; op_q<=op; count<=1; out_trunc<=0.
  - If in_last or MAX_WORDS==1: go to DONE; out_trunc<=(!in_last).
  - Else go to ACCUM.
- ACCUM, on accept:
  - acc<=acc OR/AND/XOR in_data per op_q; NOR folds as OR. count<=count+1.
  - If in_last: go to DONE, out_trunc<=0.
  - Else if count+1==MAX_WORDS: go to DONE, out_trunc<=1. Next beat starts a new burst.
  - No accept: hold.
- Changes on op after the first beat are ignored until the next burst.
- DONE:
  - out_valid=1. out_data = (op_q==11) ? ~acc : acc. out_count and out_trunc are held.
  - All outputs are stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid=0 next cycle.
  - in_valid is ignored; the beat is not consumed.
- Latency: out_valid rises the cycle after the terminating beat is accepted.
- out_data, out_count and out_trunc hold their last values outside DONE and are meaningful only with out_valid.
- in_last with in_valid=0 has no effect.
- count never exceeds MAX_WORDS; no wrap.

Optional Feature:
- Macro: BITWISE_ACCUM_POPCOUNT_EN.
- Defined:
  - Adds port out_ones, output, $clog2(WIDTH+1) bits: number of 1 bits in out_data (after NOR inversion).
  - Registered on entry to DONE, valid with out_valid, reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- OR: WIDTH=16, op=00, beats 16'h046A then 16'hDE57 (last), out_ready=1 -> next cycle out_valid=1, out_data=16'hDE7F, out_count=2, out_trunc=0; with POPCOUNT_EN, out_ones=13.
- AND/XOR/NOR:
  - op=01, beats 16'hF0F0, 16'hFF00, 16'hF3FF (last) -> out_data=16'hF000, out_count=3.
  - op=10, beats 16'h1234, 16'h1234, 16'h00FF (last) -> 16'h00FF.
  - op=11, beats 16'h0F00, 16'h00F0 (last) -> 16'hF00F.
- Truncation: MAX_WORDS=4, op=00, five beats 16'h0001, 0002, 0004, 0008, 0010 with in_last=0, the fifth with last=1:
  - First result out_data=16'h000F, out_count=4, out_trunc=1.
  - Second result out_data=16'h0010, out_count=1, out_trunc=0.
- Backpressure: result ready, out_ready=0 for 3 cycles while in_valid=1 with in_data=16'hFFFF:
  - in_ready=0; out_data/out_count stable; no beat consumed.
  - Release out_ready -> out_valid drops next cycle; then 16'hFFFF is accepted as a new burst.
- Mid-burst op change and reset:
  - op=00 on first beat 16'h0F0F, op=01 on second beat 16'hF000 (last) -> OR result 16'hFF0F.
  - Separately, rst_n=0 for one edge after two beats of a burst -> out_valid=0, in_ready=1; a new single-beat burst 16'h0003 (last) yields out_data=16'h0003, out_count=1.
